// File: rtl/riscv_alu_pkg.sv
// riscv_alu_pkg
// Shared encodings for the ALU control path: ALU_Op class codes from the main
// control unit, ALU operation codes driven to the EX-stage ALU, the funct7
// patterns that select base / alternate / M-extension behaviour, the RV32M
// funct3 codes, the sequencer FSM states and the latency counter width.
package riscv_alu_pkg;

    // ALU_Op classes from the main control unit
    localparam logic [2:0] ALUOP_RTYPE  = 3'b000;
    localparam logic [2:0] ALUOP_IARITH = 3'b001;
    localparam logic [2:0] ALUOP_LUI    = 3'b010;
    localparam logic [2:0] ALUOP_LDST   = 3'b011;
    localparam logic [2:0] ALUOP_BRANCH = 3'b100;
    localparam logic [2:0] ALUOP_JUMP   = 3'b101;
    localparam logic [2:0] ALUOP_AUIPC  = 3'b110;
    localparam logic [2:0] ALUOP_ILL    = 3'b111;

    // ALU operation codes
    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLL    = 4'd5,
        OP_SRL    = 4'd6,
        OP_SRA    = 4'd7,
        OP_LUI    = 4'd8,
        OP_SLT    = 4'd9,
        OP_SLTU   = 4'd10,
        OP_MULDIV = 4'd15
    } alu_op_e;

    // funct7 patterns
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // RV32M funct3 codes; bit 2 separates the divide group from the multiply group
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Latency counter is wide enough for any occupancy in 1..255
    localparam int CNT_W = $clog2(256);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ctrl_state_e;

    // Base integer map shared by R-type funct7=0000000 and most I-arith funct3
    function automatic alu_op_e base_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode
// Purely combinational decode of {ALU_Op, funct7, funct3} into an ALU operation.
// Ports:
//   alu_op_i     in  3  class from the main control unit
//   funct7_i     in  7  instruction[31:25]
//   funct3_i     in  3  instruction[14:12]
//   op_o         out 4  ALU operation code (ADD on illegal)
//   md_func_o    out 3  funct3 for the mul/div unit, 0 unless MULDIV
//   is_muldiv_o  out 1  operation needs the multi-cycle mul/div unit
//   illegal_o    out 1  combination is not a legal instruction
module alu_op_decode
    import riscv_alu_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [2:0] alu_op_i,
    input  logic [6:0] funct7_i,
    input  logic [2:0] funct3_i,
    output logic [3:0] op_o,
    output logic [2:0] md_func_o,
    output logic       is_muldiv_o,
    output logic       illegal_o
);

    alu_op_e op;

    always_comb begin
        op          = OP_ADD;
        md_func_o   = 3'b000;
        is_muldiv_o = 1'b0;
        illegal_o   = 1'b0;
        case (alu_op_i)
            ALUOP_RTYPE: begin
                if (funct7_i == F7_BASE) begin
                    op = base_op(funct3_i);
                end else if (funct7_i == F7_ALT) begin
                    if (funct3_i == 3'b000) begin
                        op = OP_SUB;
                    end else if (funct3_i == 3'b101) begin
                        op = OP_SRA;
                    end else begin
                        illegal_o = 1'b1;
                    end
                end else if ((funct7_i == F7_MULDIV) && (ENABLE_M != 0)) begin
                    op          = OP_MULDIV;
                    md_func_o   = funct3_i;
                    is_muldiv_o = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            ALUOP_IARITH: begin
                // funct7 is immediate bits except for the shift encodings
                case (funct3_i)
                    3'b001: begin
                        if (funct7_i == F7_BASE) begin
                            op = OP_SLL;
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (funct7_i == F7_BASE) begin
                            op = OP_SRL;
                        end else if (funct7_i == F7_ALT) begin
                            op = OP_SRA;
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    default: op = base_op(funct3_i);
                endcase
            end
            ALUOP_LUI:    op = OP_LUI;
            ALUOP_LDST:   op = OP_ADD;
            ALUOP_JUMP:   op = OP_ADD;
            ALUOP_AUIPC:  op = OP_ADD;
            ALUOP_BRANCH: begin
                // BEQ/BNE compare by subtraction; signed and unsigned ordering use SLT/SLTU
                case (funct3_i[2:1])
                    2'b00:   op = OP_SUB;
                    2'b10:   op = OP_SLT;
                    2'b11:   op = OP_SLTU;
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign op_o = op;

endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq
// Registered ALU control at the ID/EX boundary. Decodes the incoming
// instruction every cycle while idle; a mul/div operation parks the block in
// BUSY, holding its decode outputs and stalling upstream until the mul/div
// latency has elapsed.
// Ports:
//   clk, reset         clock (rising edge), synchronous active-high reset
//   valid_i            decode stage presents an instruction
//   flush_i            kill the held or in-flight operation at the next edge
//   funct7_i/ALU_Op_i/funct3_i  instruction fields and class
//   ALU_Operation_o    registered ALU operation code
//   md_func_o          registered mul/div funct3, 0 when not MULDIV
//   valid_o            outputs describe a live instruction
//   illegal_o          the registered instruction is illegal
//   md_start_o         one-cycle pulse starting the mul/div unit
//   md_done_o          one-cycle pulse, mul/div result captured this cycle
//   stall_o            upstream must hold its inputs
module alu_control_seq
    import riscv_alu_pkg::*;
#(
    parameter int OP_W       = 4,
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      ALU_Op_i,
    input  logic [2:0]      funct3_i,
    output logic [OP_W-1:0] ALU_Operation_o,
    output logic [2:0]      md_func_o,
    output logic            valid_o,
    output logic            illegal_o,
    output logic            md_start_o,
    output logic            md_done_o,
    output logic            stall_o
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [3:0] dec_op;
    logic [2:0] dec_md_func;
    logic       dec_is_muldiv;
    logic       dec_illegal;

    alu_op_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .alu_op_i    (ALU_Op_i),
        .funct7_i    (funct7_i),
        .funct3_i    (funct3_i),
        .op_o        (dec_op),
        .md_func_o   (dec_md_func),
        .is_muldiv_o (dec_is_muldiv),
        .illegal_o   (dec_illegal)
    );

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [2:0]       md_func_q, md_func_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;
    logic             md_start_q, md_start_d;

    logic busy_hold;
    assign busy_hold = (state_q == ST_BUSY) && (count_q != '0);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        md_func_d  = md_func_q;
        valid_d    = valid_q;
        illegal_d  = illegal_q;
        md_start_d = 1'b0;
        if (flush_i) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            op_d      = OP_W'(OP_ADD);
            md_func_d = 3'b000;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (busy_hold) begin
            count_d = count_q - 1'b1;
        end else begin
            // IDLE, or the done cycle of BUSY: both sample a new instruction
            state_d = ST_IDLE;
            count_d = '0;
            if (valid_i) begin
                op_d      = OP_W'(dec_op);
                md_func_d = dec_md_func;
                valid_d   = 1'b1;
                illegal_d = dec_illegal;
                if (dec_is_muldiv) begin
                    state_d    = ST_BUSY;
                    count_d    = funct3_i[2] ? DIV_LOAD : MUL_LOAD;
                    md_start_d = 1'b1;
                end
            end else begin
                op_d      = OP_W'(OP_ADD);
                md_func_d = 3'b000;
                valid_d   = 1'b0;
                illegal_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            op_q       <= '0;
            md_func_q  <= 3'b000;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            md_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            md_func_q  <= md_func_d;
            valid_q    <= valid_d;
            illegal_q  <= illegal_d;
            md_start_q <= md_start_d;
        end
    end

    assign ALU_Operation_o = op_q;
    assign md_func_o       = md_func_q;
    assign valid_o         = valid_q;
    assign illegal_o       = illegal_q;
    assign md_start_o      = md_start_q;
    assign stall_o         = busy_hold;
    assign md_done_o       = (state_q == ST_BUSY) && (count_q == '0);

endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq
// Three instances with different parameter sets share one stimulus stream:
//   0: ENABLE_M=1, MUL_CYCLES=2, DIV_CYCLES=32
//   1: ENABLE_M=1, MUL_CYCLES=1, DIV_CYCLES=3
//   2: ENABLE_M=0, MUL_CYCLES=3, DIV_CYCLES=5
// Every cycle each instance is compared against a reference model; table
// vectors and hand-written sequences add explicit expected constants.
module tb_alu_control_seq;

    localparam int NDUT = 3;
    localparam int P_M[NDUT]   = '{1, 1, 0};
    localparam int P_MUL[NDUT] = '{2, 1, 3};
    localparam int P_DIV[NDUT] = '{32, 3, 5};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [6:0] funct7_i = '0;
    logic [2:0] ALU_Op_i = '0;
    logic [2:0] funct3_i = '0;

    logic [3:0] op_w [NDUT];
    logic [2:0] func_w [NDUT];
    logic       valid_w [NDUT];
    logic       ill_w [NDUT];
    logic       start_w [NDUT];
    logic       done_w [NDUT];
    logic       stall_w [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        alu_control_seq #(
            .OP_W       (4),
            .ENABLE_M   (P_M[g]),
            .MUL_CYCLES (P_MUL[g]),
            .DIV_CYCLES (P_DIV[g])
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .valid_i         (valid_i),
            .flush_i         (flush_i),
            .funct7_i        (funct7_i),
            .ALU_Op_i        (ALU_Op_i),
            .funct3_i        (funct3_i),
            .ALU_Operation_o (op_w[g]),
            .md_func_o       (func_w[g]),
            .valid_o         (valid_w[g]),
            .illegal_o       (ill_w[g]),
            .md_start_o      (start_w[g]),
            .md_done_o       (done_w[g]),
            .stall_o         (stall_w[g])
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase = cycle index inside a mul/div occupancy (1..lat), 0 when not in one
    int         m_phase [NDUT];
    int         m_lat [NDUT];
    logic [3:0] m_op [NDUT];
    logic [2:0] m_func [NDUT];
    logic       m_valid [NDUT];
    logic       m_ill [NDUT];

    task automatic ref_decode(input int en_m, input logic [2:0] cls, input logic [2:0] f3,
                              input logic [6:0] f7, output logic [3:0] op,
                              output logic [2:0] func, output logic md, output logic ill);
        logic [3:0] base [8];
        base = '{4'd0, 4'd5, 4'd9, 4'd10, 4'd4, 4'd6, 4'd3, 4'd2};
        op = 4'd0; func = 3'd0; md = 1'b0; ill = 1'b0;
        case (cls)
            3'd0: begin
                if (f7 == 7'h00) op = base[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) op = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) op = 4'd7;
                else if (f7 == 7'h01 && en_m != 0) begin op = 4'd15; func = f3; md = 1'b1; end
                else ill = 1'b1;
            end
            3'd1: begin
                if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
                else if (f3 == 3'd5 && f7 == 7'h20) op = 4'd7;
                else if (f3 == 3'd5 && f7 != 7'h00) ill = 1'b1;
                else op = base[f3];
            end
            3'd2: op = 4'd8;
            3'd4: begin
                if (f3 <= 3'd1) op = 4'd1;
                else if (f3 <= 3'd3) ill = 1'b1;
                else if (f3 <= 3'd5) op = 4'd9;
                else op = 4'd10;
            end
            3'd7: ill = 1'b1;
            default: op = 4'd0;
        endcase
    endtask

    task automatic model_clear(input int i);
        m_phase[i] = 0; m_op[i] = '0; m_func[i] = '0; m_valid[i] = 1'b0; m_ill[i] = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] op;
        logic [2:0] func;
        logic       md, ill;
        for (int i = 0; i < NDUT; i++) begin
            if (reset || flush_i) begin
                model_clear(i);
            end else if (m_phase[i] > 0 && m_phase[i] < m_lat[i]) begin
                m_phase[i]++;
            end else if (!valid_i) begin
                model_clear(i);
            end else begin
                ref_decode(P_M[i], ALU_Op_i, funct3_i, funct7_i, op, func, md, ill);
                m_op[i] = op; m_func[i] = func; m_valid[i] = 1'b1; m_ill[i] = ill;
                m_phase[i] = md ? 1 : 0;
                m_lat[i] = funct3_i[2] ? P_DIV[i] : P_MUL[i];
            end
        end
    endtask

    function automatic logic [12:0] dut_vec(input int i);
        return {op_w[i], func_w[i], valid_w[i], ill_w[i], start_w[i], done_w[i], stall_w[i]};
    endfunction

    function automatic logic [12:0] exp_vec(input int i);
        logic s, d, st;
        s  = (m_phase[i] == 1);
        d  = (m_phase[i] > 0) && (m_phase[i] == m_lat[i]);
        st = (m_phase[i] > 0) && (m_phase[i] < m_lat[i]);
        return {m_op[i], m_func[i], m_valid[i], m_ill[i], s, d, st};
    endfunction

    // One clock: model advances with the edge, outputs compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) chk($sformatf("model_dut%0d", i), 32'(dut_vec(i)), 32'(exp_vec(i)));
    endtask

    task automatic drive(input logic v, input logic [2:0] cls, input logic [2:0] f3, input logic [6:0] f7);
        valid_i = v; ALU_Op_i = cls; funct3_i = f3; funct7_i = f7;
    endtask

    typedef struct {
        logic [2:0] cls;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] op;
        logic       ill;
    } vec_t;

    vec_t vecs [19];
    logic done_seen;

    initial begin
        for (int i = 0; i < NDUT; i++) begin model_clear(i); m_lat[i] = 1; end

        vecs[0]  = '{3'd0, 3'd5, 7'h20, 4'd7,  1'b0};
        vecs[1]  = '{3'd0, 3'd1, 7'h20, 4'd0,  1'b1};
        vecs[2]  = '{3'd4, 3'd6, 7'h00, 4'd10, 1'b0};
        vecs[3]  = '{3'd1, 3'd5, 7'h20, 4'd7,  1'b0};
        vecs[4]  = '{3'd2, 3'd3, 7'h11, 4'd8,  1'b0};
        vecs[5]  = '{3'd7, 3'd0, 7'h00, 4'd0,  1'b1};
        vecs[6]  = '{3'd0, 3'd0, 7'h00, 4'd0,  1'b0};
        vecs[7]  = '{3'd0, 3'd2, 7'h00, 4'd9,  1'b0};
        vecs[8]  = '{3'd0, 3'd7, 7'h00, 4'd2,  1'b0};
        vecs[9]  = '{3'd0, 3'd0, 7'h7f, 4'd0,  1'b1};
        vecs[10] = '{3'd1, 3'd1, 7'h20, 4'd0,  1'b1};
        vecs[11] = '{3'd1, 3'd0, 7'h20, 4'd0,  1'b0};
        vecs[12] = '{3'd1, 3'd6, 7'h55, 4'd3,  1'b0};
        vecs[13] = '{3'd4, 3'd2, 7'h00, 4'd0,  1'b1};
        vecs[14] = '{3'd4, 3'd1, 7'h00, 4'd1,  1'b0};
        vecs[15] = '{3'd6, 3'd4, 7'h3c, 4'd0,  1'b0};
        vecs[16] = '{3'd5, 3'd0, 7'h00, 4'd0,  1'b0};
        vecs[17] = '{3'd3, 3'd2, 7'h00, 4'd0,  1'b0};
        vecs[18] = '{3'd1, 3'd5, 7'h01, 4'd0,  1'b1};

        // Reset held three cycles, then released with valid_i low
        repeat (3) cycle();
        reset = 1'b0;
        repeat (3) begin
            cycle();
            chk("post_reset_zero", 32'(dut_vec(0)), 32'd0);
        end

        // Table vectors, back to back
        foreach (vecs[k]) begin
            drive(1'b1, vecs[k].cls, vecs[k].f3, vecs[k].f7);
            cycle();
            chk($sformatf("vec%0d_op", k), 32'(op_w[0]), 32'(vecs[k].op));
            chk($sformatf("vec%0d_ill", k), 32'(ill_w[0]), 32'(vecs[k].ill));
            chk($sformatf("vec%0d_valid", k), 32'(valid_w[0]), 32'd1);
        end
        drive(1'b0, 3'd0, 3'd0, 7'h00);
        cycle();
        chk("idle_after_table", 32'(dut_vec(0)), 32'd0);

        // DIV on instance 0 (32 cycles)
        drive(1'b1, 3'd0, 3'd4, 7'h01);
        cycle();
        drive(1'b0, 3'd0, 3'd0, 7'h00);
        chk("div_start", 32'(start_w[0]), 32'd1);
        chk("div_op", 32'(op_w[0]), 32'd15);
        for (int k = 1; k <= 32; k++) begin
            if (k > 1) cycle();
            chk($sformatf("div_stall_c%0d", k), 32'(stall_w[0]), 32'(k < 32));
            chk($sformatf("div_done_c%0d", k), 32'(done_w[0]), 32'(k == 32));
            chk($sformatf("div_func_c%0d", k), 32'(func_w[0]), 32'd4);
            chk($sformatf("div_valid_c%0d", k), 32'(valid_w[0]), 32'd1);
        end
        cycle();
        chk("div_after_done", 32'(dut_vec(0)), 32'd0);
        repeat (4) cycle();

        // MUL with one-cycle latency on instance 1, directly followed by ADD
        drive(1'b1, 3'd0, 3'd0, 7'h01);
        cycle();
        chk("mul1_start", 32'(start_w[1]), 32'd1);
        chk("mul1_done", 32'(done_w[1]), 32'd1);
        chk("mul1_stall", 32'(stall_w[1]), 32'd0);
        chk("mul1_op", 32'(op_w[1]), 32'd15);
        drive(1'b1, 3'd0, 3'd0, 7'h00);
        cycle();
        drive(1'b0, 3'd0, 3'd0, 7'h00);
        chk("add_after_mul1", 32'(dut_vec(1)), 32'({4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        repeat (6) cycle();

        // RV32M disabled: MUL is illegal on instance 2
        drive(1'b1, 3'd0, 3'd0, 7'h01);
        cycle();
        drive(1'b0, 3'd0, 3'd0, 7'h00);
        chk("nom_mul", 32'(dut_vec(2)), 32'({4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        repeat (6) cycle();

        // Flush during a DIV: asserted in cycle N+5
        drive(1'b1, 3'd0, 3'd6, 7'h01);
        cycle();
        drive(1'b0, 3'd0, 3'd0, 7'h00);
        repeat (4) cycle();
        flush_i = 1'b1;
        drive(1'b1, 3'd2, 3'd0, 7'h00);
        cycle();
        flush_i = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 7'h00);
        chk("flush_clears", 32'(dut_vec(0)), 32'd0);
        done_seen = 1'b0;
        repeat (40) begin
            cycle();
            if (done_w[0]) done_seen = 1'b1;
        end
        chk("flush_no_done", 32'(done_seen), 32'd0);

        // Reset mid-BUSY
        drive(1'b1, 3'd0, 3'd5, 7'h01);
        cycle();
        drive(1'b0, 3'd0, 3'd0, 7'h00);
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("reset_mid_busy", 32'(dut_vec(0)), 32'd0);
        repeat (2) cycle();

        // Randomized traffic against the model
        repeat (1500) begin
            logic [6:0] f7;
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), f7);
            flush_i = ($urandom_range(0, 24) == 0);
            reset   = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 7'h00);
        repeat (40) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
